// File: rtl/tt_um_example_adder_pkg.sv
// Shared status-word layout for the example adder: bit positions, widths and the packed status view.
// No logic; no latency. No backpressure.
// Imported by the status register and the top module.
package tt_um_example_adder_pkg;

    localparam int CNT_W        = 6;
    localparam int STAT_W       = 8;
    localparam int STAT_CARRY   = 0;
    localparam int STAT_OVF     = 1;
    localparam int STAT_CNT_LSB = 2;

    // Field order mirrors the bit positions above: cnt on top, carry in bit 0.
    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic             carry;
    } status_t;

    function automatic logic [STAT_W-1:0] pack_status(input status_t s);
        logic [STAT_W-1:0] w;
        w                                 = '0;
        w[STAT_CARRY]                     = s.carry;
        w[STAT_OVF]                       = s.ovf;
        w[STAT_CNT_LSB +: CNT_W]          = s.cnt;
        return w;
    endfunction

endpackage

// File: rtl/example_status_reg.sv
// Status register: last-cycle carry, sticky overflow and a wrapping sample counter.
// Latency: one enabled clock edge; status reflects the previous enabled edge.
// No backpressure: ena=0 simply holds all state.
module example_status_reg
    import tt_um_example_adder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              carry,
    output logic [STAT_W-1:0] status
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    status_t stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else if (ena) begin
            stat_q.carry <= carry;
            // Overflow is sticky: only reset clears it.
            stat_q.ovf   <= stat_q.ovf | carry;
            stat_q.cnt   <= stat_q.cnt + CNT_ONE;
        end
    end

    always_comb begin
        status = '0;
        status = pack_status(stat_q);
    end

endmodule

// File: rtl/tt_um_example_adder.sv
// Tiny Tapeout 8-bit adder: combinational sum on uo_out, registered status on uio_out.
// Latency: sum is zero-latency; status reflects the previous enabled edge.
// No backpressure; uio pins are never driven (uio_oe tied low).
module tt_um_example_adder
    import tt_um_example_adder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [8:0] sum9;

    // Sum path deliberately ignores ena and rst_n.
    assign sum9    = {1'b0, ui_in} + {1'b0, uio_in};
    assign uo_out  = sum9[7:0];
    assign uio_oe  = 8'h00;

    example_status_reg u_status (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .carry  (sum9[8]),
        .status (uio_out)
    );

endmodule

// File: tb/tb_tt_um_example_adder.sv
// Directed self-checking bench for tt_um_example_adder.
module tb_tt_um_example_adder;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;

    tt_um_example_adder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        repeat (10) tick();
        checks++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_uo_out: got %h expected %h", uo_out, 8'h00); end
        checks++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out: got %h expected %h", uio_out, 8'h00); end
        checks++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe: got %h expected %h", uio_oe, 8'h00); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_add();
        ena    = 1'b1;
        ui_in  = 8'd20;
        uio_in = 8'd30;
        tick();
        checks++;
        if (uo_out !== 8'd50) begin errors++; $display("FAIL basic_sum: got %0d expected %0d", uo_out, 50); end
        checks++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL basic_oe: got %h expected %h", uio_oe, 8'h00); end
        // cnt=1, no carry, no overflow
        checks++;
        if (uio_out !== 8'h04) begin errors++; $display("FAIL basic_status: got %h expected %h", uio_out, 8'h04); end
    endtask

    task automatic test_wrap_carry();
        ui_in  = 8'd200;
        uio_in = 8'd100;
        #1;
        checks++;
        if (uo_out !== 8'd44) begin errors++; $display("FAIL wrap_sum: got %0d expected %0d", uo_out, 44); end
        tick();
        checks++;
        if (uio_out[1:0] !== 2'b11) begin errors++; $display("FAIL wrap_carry_ovf: got %b expected %b", uio_out[1:0], 2'b11); end
        checks++;
        if (uio_out !== 8'h0B) begin errors++; $display("FAIL wrap_status: got %h expected %h", uio_out, 8'h0B); end
        ui_in  = 8'd1;
        uio_in = 8'd1;
        tick();
        checks++;
        if (uio_out[0] !== 1'b0) begin errors++; $display("FAIL carry_clears: got %b expected %b", uio_out[0], 1'b0); end
        checks++;
        if (uio_out[1] !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", uio_out[1], 1'b1); end
        checks++;
        if (uio_out !== 8'h0E) begin errors++; $display("FAIL after_1p1_status: got %h expected %h", uio_out, 8'h0E); end
    endtask

    task automatic test_enable_gating();
        logic [7:0] a_vec [5];
        logic [7:0] b_vec [5];
        logic [7:0] s_vec [5];
        a_vec = '{8'd10, 8'd255, 8'd128, 8'd0,  8'd99};
        b_vec = '{8'd7,  8'd2,   8'd128, 8'd0,  8'd1};
        s_vec = '{8'd17, 8'd1,   8'd0,   8'd0,  8'd100};
        apply_reset();
        ena    = 1'b1;
        ui_in  = 8'd5;
        uio_in = 8'd6;
        repeat (3) tick();
        checks++;
        if (uio_out[7:2] !== 6'd3) begin errors++; $display("FAIL gate_cnt_run: got %0d expected %0d", uio_out[7:2], 3); end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ui_in  = a_vec[i];
            uio_in = b_vec[i];
            tick();
            checks++;
            if (uo_out !== s_vec[i]) begin errors++; $display("FAIL gate_sum_%0d: got %0d expected %0d", i, uo_out, s_vec[i]); end
        end
        // Carrying inputs above must not have reached the held status.
        checks++;
        if (uio_out !== 8'h0C) begin errors++; $display("FAIL gate_hold: got %h expected %h", uio_out, 8'h0C); end
    endtask

    task automatic test_boundaries();
        apply_reset();
        ena    = 1'b1;
        ui_in  = 8'd255;
        uio_in = 8'd1;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL b255p1_sum: got %h expected %h", uo_out, 8'h00); end
        tick();
        checks++;
        if (uio_out !== 8'h07) begin errors++; $display("FAIL b255p1_status: got %h expected %h", uio_out, 8'h07); end
        ui_in  = 8'd255;
        uio_in = 8'd255;
        #1;
        checks++;
        if (uo_out !== 8'hFE) begin errors++; $display("FAIL b255p255_sum: got %h expected %h", uo_out, 8'hFE); end
        tick();
        checks++;
        if (uio_out !== 8'h0B) begin errors++; $display("FAIL b255p255_status: got %h expected %h", uio_out, 8'h0B); end
        ui_in  = 8'd0;
        uio_in = 8'd0;
        #1;
        checks++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL b0p0_sum: got %h expected %h", uo_out, 8'h00); end
        tick();
        checks++;
        if (uio_out !== 8'h0E) begin errors++; $display("FAIL b0p0_status: got %h expected %h", uio_out, 8'h0E); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        ena    = 1'b1;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        repeat (63) tick();
        checks++;
        if (uio_out !== 8'hFC) begin errors++; $display("FAIL cnt_63: got %h expected %h", uio_out, 8'hFC); end
        tick();
        checks++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL cnt_64_wrap: got %h expected %h", uio_out, 8'h00); end
        tick();
        checks++;
        if (uio_out !== 8'h04) begin errors++; $display("FAIL cnt_65: got %h expected %h", uio_out, 8'h04); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        ena    = 1'b1;
        ui_in  = 8'd200;
        uio_in = 8'd100;
        tick();
        ui_in  = 8'd1;
        uio_in = 8'd2;
        repeat (9) tick();
        // cnt=10, ovf=1, carry=0
        checks++;
        if (uio_out !== 8'h2A) begin errors++; $display("FAIL arst_prestate: got %h expected %h", uio_out, 8'h2A); end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL arst_immediate: got %h expected %h", uio_out, 8'h00); end
        ui_in  = 8'd77;
        uio_in = 8'd200;
        #1;
        checks++;
        if (uo_out !== 8'd21) begin errors++; $display("FAIL arst_sum: got %0d expected %0d", uo_out, 21); end
        tick();
        checks++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL arst_held: got %h expected %h", uio_out, 8'h00); end
        checks++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL arst_oe: got %h expected %h", uio_oe, 8'h00); end
        rst_n  = 1'b1;
        ui_in  = 8'd7;
        uio_in = 8'd8;
        tick();
        checks++;
        if (uio_out !== 8'h04) begin errors++; $display("FAIL arst_first_edge: got %h expected %h", uio_out, 8'h04); end
        checks++;
        if (uo_out !== 8'd15) begin errors++; $display("FAIL arst_release_sum: got %0d expected %0d", uo_out, 15); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        ena    = 1'b0;
        ui_in  = 8'd0;
        uio_in = 8'd0;
        test_reset();
        test_basic_add();
        test_wrap_carry();
        test_enable_gating();
        test_boundaries();
        test_counter_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
